// File: rtl/base_sram_pkg.sv
// Shared constants for the SRAM read-port slice: SRAM read latency and return-buffer depth.
package base_sram_pkg;

  localparam int RD_LAT    = 1;
  localparam int BUF_DEPTH = 3;

endpackage

// File: rtl/base_sram_rdbuf.sv
// Return buffer: circular FIFO, pointers wrap modulo depth; head is combinational, one cycle from push to head.
// Never refuses a push; the parent guarantees no push into a full buffer via its occupancy credit.
module base_sram_rdbuf #(
  parameter int width = 8,
  parameter int depth = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [0:width-1]             push_d,
  input  logic                         pop,
  output logic [0:width-1]             head,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [0:width-1] store [depth];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= bump(wptr);
      if (pop)  rptr <= bump(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) store[wptr] <= push_d;
  end

  assign head = store[rptr];

endmodule

// File: rtl/base_sram_rdport.sv
// SRAM read port with 3-entry return buffer; 2-cycle request-to-response latency, 1 response/cycle.
// i_r is a registered-state credit (occ < 3): backpressure on o_r stalls acceptance, never loses data.
module base_sram_rdport
  import base_sram_pkg::*;
#(
  parameter int width  = 8,
  parameter int awidth = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_v,
  input  logic [0:awidth-1] i_a,
  output logic              i_r,
  output logic              o_re,
  output logic [0:awidth-1] o_ra,
  input  logic [0:width-1]  i_rd,
  output logic              o_v,
  output logic [0:width-1]  o_d,
  input  logic              o_r
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic          inflight;
  logic [CW-1:0] cnt;
  logic [CW:0]   occ;
  logic          pop;

  // Counting the in-flight read reserves its slot before the data arrives.
  assign occ  = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign i_r  = ~reset & (occ < (CW+1)'(BUF_DEPTH));
  assign o_re = i_v & i_r;
  assign o_ra = i_a;

  always_ff @(posedge clk) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= o_re;
  end

  assign o_v = ~reset & (cnt != '0);
  assign pop = o_v & o_r;

  base_sram_rdbuf #(
    .width (width),
    .depth (BUF_DEPTH)
  ) u_rdbuf (
    .clk    (clk),
    .reset  (reset),
    .push   (inflight),
    .push_d (i_rd),
    .pop    (pop),
    .head   (o_d),
    .count  (cnt)
  );

endmodule

// File: tb/tb_base_sram_rdport.sv
// Directed bench for base_sram_rdport with an SRAM model and an in-order response scoreboard.
module tb_base_sram_rdport;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_v;
  logic [0:3] i_a;
  logic       i_r;
  logic       o_re;
  logic [0:3] o_ra;
  logic [0:7] i_rd;
  logic       o_v;
  logic [0:7] o_d;
  logic       o_r;

  logic [7:0] mem [16];
  logic [7:0] expq [$];
  int         nvec = 0;
  int         nmiss = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;

  always #5 clk = ~clk;

  base_sram_rdport #(.width(8), .awidth(4)) dut (
    .clk   (clk),
    .reset (reset),
    .i_v   (i_v),
    .i_a   (i_a),
    .i_r   (i_r),
    .o_re  (o_re),
    .o_ra  (o_ra),
    .i_rd  (i_rd),
    .o_v   (o_v),
    .o_d   (o_d),
    .o_r   (o_r)
  );

  // SRAM model: one-cycle read, garbage when not reading.
  always @(posedge clk) i_rd <= o_re ? mem[o_ra] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: outstanding = accepted-but-not-popped, which must equal the DUT occupancy.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ov", o_v, 1'b0);
      chk("rst_ir", i_r, 1'b0);
      chk("rst_re", o_re, 1'b0);
      expq.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("credit", i_r, expq.size() < 3);
      if (prev_stall) begin
        chk("stall_ov", o_v, 1'b1);
        chk("stall_od", o_d, prev_d);
      end
      if (o_v && o_r) begin
        if (expq.size() == 0) chk("spurious_ov", o_v, 1'b0);
        else chk("sb_data", o_d, expq.pop_front());
      end
      if (o_re) expq.push_back(mem[o_ra]);
      prev_stall <= o_v & ~o_r;
      prev_d     <= o_d;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int pops;
    for (int k = 0; k < 16; k++) mem[k] = 8'(k * 8'h13) ^ 8'h5A;
    mem[5] = 8'hA5;
    mem[7] = 8'h3C;
    reset = 1'b1; i_v = 1'b0; i_a = '0; o_r = 1'b1;

    // Reset state, with a request pending to show o_re is forced low.
    nxt(); i_v = 1'b1; i_a = 4'd3;
    @(negedge clk);
    chk("reset_ov", o_v, 1'b0);
    chk("reset_ir", i_r, 1'b0);
    chk("reset_re", o_re, 1'b0);
    nxt(); reset = 1'b0; i_v = 1'b0;
    @(negedge clk);
    chk("ir_after_reset", i_r, 1'b1);
    chk("ov_after_reset", o_v, 1'b0);

    // Single read of mem[5].
    nxt(); i_v = 1'b1; i_a = 4'd5;
    @(negedge clk);
    chk("single_re", o_re, 1'b1);
    chk("single_ra", o_ra, 4'd5);
    nxt(); i_v = 1'b0;
    @(negedge clk);
    chk("single_ov_t1", o_v, 1'b0);
    nxt();
    @(negedge clk);
    chk("single_ov_t2", o_v, 1'b1);
    chk("single_od_t2", o_d, 8'hA5);
    nxt();
    @(negedge clk);
    chk("single_ov_t3", o_v, 1'b0);

    // Streaming 0..15 at full rate.
    for (int k = 0; k < 18; k++) begin
      nxt(); i_v = (k < 16); i_a = 4'(k);
      @(negedge clk);
      if (k < 16) chk("stream_ir", i_r, 1'b1);
      if (k >= 2) begin
        chk("stream_ov", o_v, 1'b1);
        chk("stream_od", o_d, mem[k-2]);
      end
    end
    nxt(); i_v = 1'b0;
    @(negedge clk);
    chk("stream_idle", o_v, 1'b0);

    // Backpressure: exactly three accepts, then in-order drain.
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      nxt(); i_v = 1'b1; i_a = 4'(8 + k); o_r = 1'b0;
      @(negedge clk);
      if (o_re) acc++;
      if (k == 3) chk("bp_ir_low", i_r, 1'b0);
    end
    chk("bp_accepts", acc, 3);
    chk("bp_head_ov", o_v, 1'b1);
    chk("bp_head_od", o_d, mem[8]);
    for (int j = 0; j < 4; j++) begin
      nxt(); i_v = 1'b0; o_r = 1'b1;
      @(negedge clk);
      chk("bp_drain_ov", o_v, j < 3);
      if (j < 3) chk("bp_drain_od", o_d, mem[8+j]);
    end

    // Random valid/ready traffic against the scoreboard.
    for (int k = 0; k < 2000; k++) begin
      nxt(); i_v = 1'($urandom % 2); i_a = 4'($urandom); o_r = 1'($urandom % 2);
      @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      nxt(); i_v = 1'b0; o_r = 1'b1;
      @(negedge clk);
    end
    chk("rand_drained", o_v, 1'b0);

    // Mid-operation reset with count 2 and one read in flight.
    for (int k = 0; k < 3; k++) begin
      nxt(); i_v = 1'b1; i_a = 4'(k + 1); o_r = 1'b0;
      @(negedge clk);
    end
    chk("mr_pre_ov", o_v, 1'b1);
    nxt(); i_v = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("mr_ov_rst", o_v, 1'b0);
    nxt(); reset = 1'b0; o_r = 1'b1;
    @(negedge clk);
    chk("mr_ov_next", o_v, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      @(negedge clk);
      chk("mr_no_stale", o_v, 1'b0);
    end
    nxt(); i_v = 1'b1; i_a = 4'd7;
    @(negedge clk);
    chk("mr_re7", o_re, 1'b1);
    nxt(); i_v = 1'b0;
    @(negedge clk);
    chk("mr_ov_t1", o_v, 1'b0);
    nxt();
    @(negedge clk);
    chk("mr_ov_t2", o_v, 1'b1);
    chk("mr_od_t2", o_d, 8'h3C);
    nxt();
    @(negedge clk);
    chk("mr_ov_t3", o_v, 1'b0);

    // Pointer wrap under alternating stalls.
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      nxt(); i_v = 1'b1; i_a = 4'(15 - (k % 16)); o_r = k[0];
      @(negedge clk);
      if (o_v && o_r) pops++;
    end
    for (int k = 0; k < 6; k++) begin
      nxt(); i_v = 1'b0; o_r = 1'b1;
      @(negedge clk);
      if (o_v && o_r) pops++;
    end
    chk("wrap_pops_gt6", pops > 6, 1'b1);
    chk("wrap_drained", o_v, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
